// File: rtl/shr_pattern_sequencer.sv
// Serial loader for the GPIO shift-register chain: captures a pattern on
// request and clocks it out with sr_clk/sr_data, then strobes sr_le.
module shr_pattern_sequencer #(
    parameter int WIDTH     = 620,
    parameter int DIV       = 4,
    parameter int LATCH_CYC = 2,
    parameter int MSB_FIRST = 0,
    parameter int CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             update_req,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    output logic             sr_clk,
    output logic             sr_data,
    output logic             sr_le,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    bit_cnt
);

    localparam int CMAX = (DIV > LATCH_CYC) ? DIV : LATCH_CYC;
    localparam int DW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOW   = 3'd1,
        HIGH  = 3'd2,
        LATCH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [DW-1:0]    r_div;
    logic [DW-1:0]    w_div_n;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_shadow_n;
    logic [CW-1:0]    r_bit_cnt;
    logic [CW-1:0]    w_cnt_n;
    logic             r_pending;
    logic             w_pending_n;
    logic [1:0]       r_sync;
    logic             r_sync_d;
    logic             r_trig;
    logic [1:0]       r_arm;
    logic             r_sr_clk;
    logic             r_sr_data;
    logic             r_sr_le;
    logic             r_busy;
    logic             r_done;
    logic             w_armed;
    logic             w_req;
    logic             w_bit_n;
    logic             w_drive_n;

    assign w_armed = (r_arm == 2'd3);
    assign w_req   = r_trig | (start & w_armed);

    // Arm gating sits at the edge detector so a level held high
    // through reset release can never produce a trigger.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_sync   <= 2'b00;
            r_sync_d <= 1'b0;
            r_trig   <= 1'b0;
            r_arm    <= 2'd0;
        end else begin
            r_sync   <= {r_sync[0], update_req};
            r_sync_d <= r_sync[1];
            r_trig   <= r_sync[1] & ~r_sync_d & w_armed;
            if (!w_armed) begin
                r_arm <= r_arm + 2'd1;
            end
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_div_n     = r_div;
        w_shadow_n  = r_shadow;
        w_cnt_n     = r_bit_cnt;
        w_pending_n = r_pending;
        unique case (r_state)
            IDLE: begin
                if (w_req || r_pending) begin
                    w_shadow_n  = pattern;
                    w_pending_n = 1'b0;
                    w_cnt_n     = '0;
                    w_div_n     = '0;
                    w_state_n   = LOW;
                end
            end
            LOW: begin
                if (r_div == DW'(DIV - 1)) begin
                    w_div_n   = '0;
                    w_state_n = HIGH;
                end else begin
                    w_div_n = r_div + DW'(1);
                end
            end
            HIGH: begin
                if (r_div == DW'(DIV - 1)) begin
                    w_div_n = '0;
                    if (r_bit_cnt == CW'(WIDTH - 1)) begin
                        w_state_n = LATCH;
                    end else begin
                        w_shadow_n = (MSB_FIRST != 0) ? (r_shadow << 1)
                                                      : (r_shadow >> 1);
                        w_cnt_n    = r_bit_cnt + CW'(1);
                        w_state_n  = LOW;
                    end
                end else begin
                    w_div_n = r_div + DW'(1);
                end
            end
            LATCH: begin
                if (r_div == DW'(LATCH_CYC - 1)) begin
                    w_div_n   = '0;
                    w_cnt_n   = '0;
                    w_state_n = DONE;
                end else begin
                    w_div_n = r_div + DW'(1);
                end
            end
            DONE: begin
                w_cnt_n   = '0;
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
        if (r_state != IDLE && w_req) begin
            w_pending_n = 1'b1;
        end
    end

    assign w_bit_n   = (MSB_FIRST != 0) ? w_shadow_n[WIDTH-1] : w_shadow_n[0];
    assign w_drive_n = (w_state_n == LOW) || (w_state_n == HIGH) ||
                       (w_state_n == LATCH);

    // Outputs are registered from the next-state view so they line up
    // with the state they belong to.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_shadow  <= '0;
            r_bit_cnt <= '0;
            r_pending <= 1'b0;
            r_sr_clk  <= 1'b0;
            r_sr_data <= 1'b0;
            r_sr_le   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_div     <= w_div_n;
            r_shadow  <= w_shadow_n;
            r_bit_cnt <= w_cnt_n;
            r_pending <= w_pending_n;
            r_sr_clk  <= (w_state_n == HIGH);
            r_sr_data <= w_drive_n & w_bit_n;
            r_sr_le   <= (w_state_n == LATCH);
            r_busy    <= (w_state_n != IDLE);
            r_done    <= (w_state_n == DONE);
        end
    end

    assign sr_clk  = r_sr_clk;
    assign sr_data = r_sr_data;
    assign sr_le   = r_sr_le;
    assign busy    = r_busy;
    assign done    = r_done;
    assign bit_cnt = r_bit_cnt;

endmodule

// File: tb/tb_shr_pattern_sequencer.sv
// Bench for shr_pattern_sequencer: LSB-first and MSB-first instances
// side by side, bit scoreboard plus hand-written corner sequences.
module tb_shr_pattern_sequencer;

    typedef struct {
        logic       b;
        int         idx;
    } obs_t;

    typedef struct {
        logic [7:0] pat;
        logic [7:0] seq_lsb;
        logic [7:0] seq_msb;
    } vec_t;

    logic       clk;
    logic       aclr;
    logic       update_req;
    logic       start;
    logic [7:0] pattern;
    logic       sr_clk0, sr_data0, sr_le0, busy0, done0;
    logic       sr_clk1, sr_data1, sr_le1, busy1, done1;
    logic [2:0] bit_cnt0, bit_cnt1;

    int n_chk;
    int n_fail;

    obs_t e0[$];
    obs_t e1[$];
    obs_t g0[$];
    obs_t g1[$];

    int rise_cnt[2];
    int hi_cnt[2];
    int le_cnt[2];
    int done_cnt[2];
    int busy_cnt[2];
    logic p_clk[2];

    shr_pattern_sequencer #(
        .WIDTH(8), .DIV(2), .LATCH_CYC(2), .MSB_FIRST(0)
    ) u_lsb (
        .clk(clk), .aclr(aclr), .update_req(update_req), .start(start),
        .pattern(pattern), .sr_clk(sr_clk0), .sr_data(sr_data0),
        .sr_le(sr_le0), .busy(busy0), .done(done0), .bit_cnt(bit_cnt0)
    );

    shr_pattern_sequencer #(
        .WIDTH(8), .DIV(2), .LATCH_CYC(2), .MSB_FIRST(1)
    ) u_msb (
        .clk(clk), .aclr(aclr), .update_req(update_req), .start(start),
        .pattern(pattern), .sr_clk(sr_clk1), .sr_data(sr_data1),
        .sr_le(sr_le1), .busy(busy1), .done(done1), .bit_cnt(bit_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (aclr) begin
            p_clk[0] <= 1'b0;
            p_clk[1] <= 1'b0;
        end else begin
            if (sr_clk0 && !p_clk[0]) begin
                g0.push_back('{b: sr_data0, idx: int'(bit_cnt0)});
                rise_cnt[0] <= rise_cnt[0] + 1;
            end
            if (sr_clk1 && !p_clk[1]) begin
                g1.push_back('{b: sr_data1, idx: int'(bit_cnt1)});
                rise_cnt[1] <= rise_cnt[1] + 1;
            end
            p_clk[0]    <= sr_clk0;
            p_clk[1]    <= sr_clk1;
            hi_cnt[0]   <= hi_cnt[0] + int'(sr_clk0);
            hi_cnt[1]   <= hi_cnt[1] + int'(sr_clk1);
            le_cnt[0]   <= le_cnt[0] + int'(sr_le0);
            le_cnt[1]   <= le_cnt[1] + int'(sr_le1);
            done_cnt[0] <= done_cnt[0] + int'(done0);
            done_cnt[1] <= done_cnt[1] + int'(done1);
            busy_cnt[0] <= busy_cnt[0] + int'(busy0);
            busy_cnt[1] <= busy_cnt[1] + int'(busy1);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] s0, input logic [7:0] s1);
        logic [7:0] a;
        logic [7:0] b;
        a = s0;
        b = s1;
        for (int i = 0; i < 8; i++) begin
            e0.push_back('{b: a[7-i], idx: i});
            e1.push_back('{b: b[7-i], idx: i});
        end
    endtask

    task automatic cmp_bits();
        obs_t x;
        obs_t y;
        chk("bits_seen_lsb", g0.size(), e0.size());
        chk("bits_seen_msb", g1.size(), e1.size());
        while (e0.size() > 0 && g0.size() > 0) begin
            x = e0.pop_front();
            y = g0.pop_front();
            chk("bit_lsb", int'(y.b), int'(x.b));
            chk("bitcnt_lsb", y.idx, x.idx);
        end
        while (e1.size() > 0 && g1.size() > 0) begin
            x = e1.pop_front();
            y = g1.pop_front();
            chk("bit_msb", int'(y.b), int'(x.b));
            chk("bitcnt_msb", y.idx, x.idx);
        end
        e0.delete();
        e1.delete();
        g0.delete();
        g1.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done0 && n < budget);
        chk("done_within_budget", int'(done0), 1);
    endtask

    task automatic run_xfer(input logic [7:0] pat,
                            input logic [7:0] s0,
                            input logic [7:0] s1);
        int b_rise[2], b_hi[2], b_le[2], b_done[2], b_busy[2];
        for (int i = 0; i < 2; i++) begin
            b_rise[i] = rise_cnt[i];
            b_hi[i]   = hi_cnt[i];
            b_le[i]   = le_cnt[i];
            b_done[i] = done_cnt[i];
            b_busy[i] = busy_cnt[i];
        end
        pattern = pat;
        push_exp(s0, s1);
        pulse_start();
        wait_done(200);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("busy_cycles", busy_cnt[i] - b_busy[i], 35);
            chk("clk_pulses", rise_cnt[i] - b_rise[i], 8);
            chk("clk_high_cycles", hi_cnt[i] - b_hi[i], 16);
            chk("le_cycles", le_cnt[i] - b_le[i], 2);
            chk("done_pulses", done_cnt[i] - b_done[i], 1);
        end
        cmp_bits();
    endtask

    vec_t vt[5];

    initial begin
        int n;
        int bd;
        int bl;
        int bb;
        n_chk      = 0;
        n_fail     = 0;
        aclr       = 1'b1;
        update_req = 1'b1;
        start      = 1'b0;
        pattern    = 8'h00;
        for (int i = 0; i < 2; i++) begin
            rise_cnt[i] = 0;
            hi_cnt[i]   = 0;
            le_cnt[i]   = 0;
            done_cnt[i] = 0;
            busy_cnt[i] = 0;
        end

        vt[0] = '{pat: 8'hA5, seq_lsb: 8'b10100101, seq_msb: 8'b10100101};
        vt[1] = '{pat: 8'h0F, seq_lsb: 8'b11110000, seq_msb: 8'b00001111};
        vt[2] = '{pat: 8'h81, seq_lsb: 8'b10000001, seq_msb: 8'b10000001};
        vt[3] = '{pat: 8'h12, seq_lsb: 8'b01001000, seq_msb: 8'b00010010};
        vt[4] = '{pat: 8'h01, seq_lsb: 8'b10000000, seq_msb: 8'b00000001};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs_lsb",
            int'({sr_clk0, sr_data0, sr_le0, busy0, done0, bit_cnt0}), 0);
        chk("rst_outputs_msb",
            int'({sr_clk1, sr_data1, sr_le1, busy1, done1, bit_cnt1}), 0);
        aclr = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_xfer_on_release", busy_cnt[0] + busy_cnt[1], 0);
        chk("no_done_on_release", done_cnt[0] + done_cnt[1], 0);
        update_req = 1'b0;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_xfer(vt[v].pat, vt[v].seq_lsb, vt[v].seq_msb);
        end

        pattern = 8'h3C;
        push_exp(8'b00111100, 8'b00111100);
        bd = done_cnt[0];
        @(posedge clk);
        #($urandom_range(1, 9)) update_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!busy0 && n < 10);
        chk("upd_latency_3to4", int'(n >= 3 && n <= 4), 1);
        wait_done(200);
        repeat (2) @(negedge clk);
        cmp_bits();
        update_req = 1'b0;
        repeat (40) @(negedge clk);
        chk("upd_single_xfer", done_cnt[0] - bd, 1);

        bd = done_cnt[0];
        bl = le_cnt[0];
        bb = rise_cnt[0];
        pattern = 8'h01;
        push_exp(8'b10000000, 8'b00000001);
        pulse_start();
        repeat (9) @(posedge clk);
        #1 pattern = 8'hFE;
        push_exp(8'b01111111, 8'b11111110);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(200);
        @(negedge clk);
        chk("gap_idle", int'(busy0), 0);
        @(negedge clk);
        chk("gap_restart", int'(busy0), 1);
        wait_done(200);
        repeat (40) @(negedge clk);
        chk("pend_done_pulses", done_cnt[0] - bd, 2);
        chk("pend_le_cycles", le_cnt[0] - bl, 4);
        chk("pend_clk_pulses", rise_cnt[0] - bb, 16);
        cmp_bits();

        pattern = 8'hFF;
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bit_cnt0 != 3'd4 && n < 100);
        chk("reach_bit4", int'(bit_cnt0), 4);
        bd = done_cnt[0];
        bl = le_cnt[0];
        aclr = 1'b1;
        #1;
        chk("midrst_outputs_lsb",
            int'({sr_clk0, sr_data0, sr_le0, busy0, done0, bit_cnt0}), 0);
        chk("midrst_outputs_msb",
            int'({sr_clk1, sr_data1, sr_le1, busy1, done1, bit_cnt1}), 0);
        e0.delete();
        e1.delete();
        g0.delete();
        g1.delete();
        repeat (2) @(posedge clk);
        #1 aclr = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_le", le_cnt[0] - bl, 0);
        chk("midrst_no_done", done_cnt[0] - bd, 0);
        run_xfer(8'hA5, 8'b10100101, 8'b10100101);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
